// File: rtl/spi_burst_controller.sv
// spi_burst_controller: decodes the SPI command byte and sequences the memory
// datapath (shift-register load, memory write, MISO enable) through
// auto-incrementing read or write bursts of unlimited length.
module spi_burst_controller #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk_rise,
    input  logic              cs_n,
    input  logic [7:0]        sr_pdata,
    output logic [ADDR_W-1:0] addr,
    output logic              dm_we,
    output logic              sr_load,
    output logic              miso_oe,
    output logic              busy,
    output logic [7:0]        byte_cnt
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_CMD          = 3'd1;
    localparam logic [2:0] S_DECODE       = 3'd2;
    localparam logic [2:0] S_READ_LOAD    = 3'd3;
    localparam logic [2:0] S_READ_SHIFT   = 3'd4;
    localparam logic [2:0] S_WRITE_SHIFT  = 3'd5;
    localparam logic [2:0] S_WRITE_COMMIT = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic              dm_we_q, dm_we_d;
    logic              sr_load_q, sr_load_d;
    logic              miso_oe_q, miso_oe_d;
    logic              busy_q, busy_d;
    logic              byte_done;
    logic [6:0]        cmd_addr;

    // Next-state, counters and address; outputs are decoded from the next state
    // so they are registered and aligned with the state they belong to.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        cmd_addr   = sr_pdata[7:1];
        byte_done  = sclk_rise && (bit_cnt_q == 3'd7);

        if (cs_n) begin
            // Deselect wins over everything; a partial byte is dropped.
            state_d = S_IDLE;
        end else begin
            // Rises are counted in every active state, including the one-cycle
            // states, so a rise there becomes bit 0 of the next byte.
            if (state_q != S_IDLE && sclk_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                S_IDLE: begin
                    state_d    = S_CMD;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'd0;
                end
                S_CMD: begin
                    if (byte_done) state_d = S_DECODE;
                end
                S_DECODE: begin
                    addr_d  = cmd_addr[ADDR_W-1:0];
                    state_d = sr_pdata[0] ? S_READ_LOAD : S_WRITE_SHIFT;
                end
                S_READ_LOAD: begin
                    state_d = S_READ_SHIFT;
                end
                S_READ_SHIFT: begin
                    if (byte_done) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                        state_d    = S_READ_LOAD;
                    end
                end
                S_WRITE_SHIFT: begin
                    if (byte_done) state_d = S_WRITE_COMMIT;
                end
                S_WRITE_COMMIT: begin
                    addr_d     = addr_q + ADDR_W'(1);
                    byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                    state_d    = S_WRITE_SHIFT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        sr_load_d = (state_d == S_READ_LOAD);
        dm_we_d   = (state_d == S_WRITE_COMMIT);
        miso_oe_d = (state_d == S_READ_SHIFT);
        busy_d    = (state_d != S_IDLE);
    end

    // State, counter, address and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            addr_q     <= '0;
            byte_cnt_q <= 8'd0;
            dm_we_q    <= 1'b0;
            sr_load_q  <= 1'b0;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            dm_we_q    <= dm_we_d;
            sr_load_q  <= sr_load_d;
            miso_oe_q  <= miso_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign addr     = addr_q;
    assign dm_we    = dm_we_q;
    assign sr_load  = sr_load_q;
    assign miso_oe  = miso_oe_q;
    assign busy     = busy_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_spi_burst_controller.sv
// Bench for spi_burst_controller: table of burst transactions plus hand-written
// latency, reset, abort and coincident-strobe sequences, with a scoreboard of
// expected memory writes and shift-register loads.
module tb_spi_burst_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk_rise;
    logic       cs_n;
    logic       mosi;
    logic [7:0] sr_pdata = 8'h00;
    logic [6:0] addr;
    logic       dm_we;
    logic       sr_load;
    logic       miso_oe;
    logic       busy;
    logic [7:0] byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [6:0] exp_rd[$];
    wr_t        mon_e;
    logic [6:0] mon_a;

    typedef struct {
        logic [7:0] cmd;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] a0;
        logic [7:0] exp_cnt;
        logic [6:0] exp_end;
    } vec_t;

    vec_t vecs[5];

    spi_burst_controller #(.ADDR_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk_rise (sclk_rise),
        .cs_n      (cs_n),
        .sr_pdata  (sr_pdata),
        .addr      (addr),
        .dm_we     (dm_we),
        .sr_load   (sr_load),
        .miso_oe   (miso_oe),
        .busy      (busy),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    // Shift register model: shifts MOSI in on every strobe while selected.
    always @(posedge clk) begin
        if (sclk_rise && !cs_n) sr_pdata <= {sr_pdata[6:0], mosi};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected pulse, addr 0x%0h at %0t", name, addr, $time);
    endtask

    // Scoreboard: every write/load pulse must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (dm_we) begin
                if (exp_wr.size() == 0) fail_now("dm_we");
                else begin
                    mon_e = exp_wr.pop_front();
                    check("dm_we addr", 32'(addr), 32'(mon_e.a));
                    check("dm_we data", 32'(sr_pdata), 32'(mon_e.d));
                end
            end
            if (sr_load) begin
                if (exp_rd.size() == 0) fail_now("sr_load");
                else begin
                    mon_a = exp_rd.pop_front();
                    check("sr_load addr", 32'(addr), 32'(mon_a));
                end
                if (miso_oe) fail_now("miso_oe during sr_load");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic b);
        mosi      = b;
        sclk_rise = 1'b1;
        step();
        sclk_rise = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        pulse(b);
        repeat (3) step();
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(b[i]);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cmd: 8'h14, nbytes: 2, d0: 8'h5A, d1: 8'hC3, a0: 7'h0A, exp_cnt: 8'd2, exp_end: 7'h0C};
        vecs[1] = '{cmd: 8'h15, nbytes: 2, d0: 8'h96, d1: 8'h0F, a0: 7'h0A, exp_cnt: 8'd2, exp_end: 7'h0C};
        vecs[2] = '{cmd: 8'hFE, nbytes: 2, d0: 8'h11, d1: 8'h22, a0: 7'h7F, exp_cnt: 8'd2, exp_end: 7'h01};
        vecs[3] = '{cmd: 8'hFF, nbytes: 1, d0: 8'hE1, d1: 8'h00, a0: 7'h7F, exp_cnt: 8'd1, exp_end: 7'h00};
        vecs[4] = '{cmd: 8'h00, nbytes: 0, d0: 8'h00, d1: 8'h00, a0: 7'h00, exp_cnt: 8'd0, exp_end: 7'h00};

        reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0; mosi = 1'b0;
        repeat (2) step();
        check("reset addr", 32'(addr), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset enables", 32'({dm_we, sr_load, miso_oe}), 32'h0);
        check("reset byte_cnt", 32'(byte_cnt), 32'h0);
        reset = 1'b0;
        step();

        // Table of back-to-back bursts, cs_n high for one cycle between them.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].cmd[0]) begin
                for (int i = 0; i <= vecs[v].nbytes; i++) exp_rd.push_back(7'(vecs[v].a0 + 7'(i)));
            end else begin
                for (int i = 0; i < vecs[v].nbytes; i++)
                    exp_wr.push_back('{a: 7'(vecs[v].a0 + 7'(i)), d: (i == 0) ? vecs[v].d0 : vecs[v].d1});
            end
            cs_n = 1'b0;
            step();
            check("txn start busy", 32'(busy), 32'h1);
            check("txn start byte_cnt", 32'(byte_cnt), 32'h0);
            send_bits(vecs[v].cmd, 7, 0);
            if (vecs[v].nbytes > 0) send_bits(vecs[v].d0, 7, 0);
            if (vecs[v].nbytes > 1) send_bits(vecs[v].d1, 7, 0);
            check("txn byte_cnt", 32'(byte_cnt), 32'(vecs[v].exp_cnt));
            check("txn miso_oe", 32'(miso_oe), 32'(vecs[v].cmd[0]));
            cs_n = 1'b1;
            step();
            check("txn end busy", 32'(busy), 32'h0);
            check("txn end miso_oe", 32'(miso_oe), 32'h0);
            check("txn end addr", 32'(addr), 32'(vecs[v].exp_end));
            check("txn end byte_cnt", 32'(byte_cnt), 32'(vecs[v].exp_cnt));
            check("txn wr drained", 32'(exp_wr.size()), 32'h0);
            check("txn rd drained", 32'(exp_rd.size()), 32'h0);
        end

        // Read latency chain, then reset in the middle of READ_SHIFT.
        exp_rd.push_back(7'h0A);
        exp_rd.push_back(7'h0B);
        cs_n = 1'b0;
        step();
        send_bits(8'h15, 7, 1);
        pulse(1'b1);
        check("decode busy", 32'(busy), 32'h1);
        check("decode addr held", 32'(addr), 32'h0);
        check("decode sr_load", 32'(sr_load), 32'h0);
        step();
        check("k+2 addr", 32'(addr), 32'h0A);
        check("k+2 sr_load", 32'(sr_load), 32'h1);
        check("k+2 miso_oe", 32'(miso_oe), 32'h0);
        step();
        check("k+3 sr_load", 32'(sr_load), 32'h0);
        check("k+3 miso_oe", 32'(miso_oe), 32'h1);
        step();
        send_bits(8'h00, 7, 1);
        check("read mid miso_oe", 32'(miso_oe), 32'h1);
        pulse(1'b0);
        check("reload addr", 32'(addr), 32'h0B);
        check("reload sr_load", 32'(sr_load), 32'h1);
        check("reload miso_oe", 32'(miso_oe), 32'h0);
        check("reload byte_cnt", 32'(byte_cnt), 32'h1);
        step();
        check("reshift miso_oe", 32'(miso_oe), 32'h1);
        repeat (2) step();
        send_bits(8'hE0, 7, 5);
        reset = 1'b1;
        step();
        check("mid reset addr", 32'(addr), 32'h0);
        check("mid reset miso_oe", 32'(miso_oe), 32'h0);
        check("mid reset busy", 32'(busy), 32'h0);
        check("mid reset byte_cnt", 32'(byte_cnt), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("post reset busy", 32'(busy), 32'h1);
        exp_rd.push_back(7'h20);
        send_bits(8'h41, 7, 1);
        pulse(1'b1);
        step();
        check("cmd41 addr", 32'(addr), 32'h20);
        check("cmd41 byte_cnt", 32'(byte_cnt), 32'h0);
        repeat (2) step();
        cs_n = 1'b1;
        step();
        check("cmd41 end busy", 32'(busy), 32'h0);
        check("cmd41 rd drained", 32'(exp_rd.size()), 32'h0);

        // Abort a write after 5 data rises; the coincident strobe is ignored.
        cs_n = 1'b0;
        step();
        send_bits(8'h20, 7, 0);
        send_bits(8'hFF, 7, 3);
        cs_n = 1'b1;
        pulse(1'b1);
        check("abort busy", 32'(busy), 32'h0);
        check("abort dm_we", 32'(dm_we), 32'h0);
        check("abort addr", 32'(addr), 32'h10);
        check("abort byte_cnt", 32'(byte_cnt), 32'h0);
        send_bits(8'hFF, 7, 5);
        check("idle strobes busy", 32'(busy), 32'h0);

        // Strobe with cs_n falling in IDLE is ignored; strobes coincident with
        // DECODE and WRITE_COMMIT start the next byte.
        exp_wr.push_back('{a: 7'h18, d: 8'hA7});
        exp_wr.push_back('{a: 7'h19, d: 8'h3C});
        cs_n = 1'b0;
        pulse(1'b1);
        step();
        send_bits(8'h30, 7, 1);
        pulse(1'b0);
        pulse(1'b1);
        repeat (3) step();
        send_bits(8'hA7, 6, 1);
        pulse(1'b1);
        pulse(1'b0);
        repeat (3) step();
        send_bits(8'h3C, 6, 0);
        check("coinc byte_cnt", 32'(byte_cnt), 32'h2);
        check("coinc addr", 32'(addr), 32'h1A);
        cs_n = 1'b1;
        step();
        check("coinc end busy", 32'(busy), 32'h0);
        check("coinc wr drained", 32'(exp_wr.size()), 32'h0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
